lcd_host_seq: RTL and testbench
===============================

Name: lcd_host_seq

Overview:
- Host-side counterpart of the LCD image controller; sits between an upstream command source and the controller's cmd/cmd_valid/busy/done interface.
- Buffers upstream commands in a FIFO and issues them only when the controller can accept them.
- Emits the one-cycle Write command and then holds off until the controller's write-back completes.
- Monitors the IRAM write-back bus and reports a per-frame checksum and write count.

Parameters:
DEPTH, 8, command FIFO entries (power of two, >=2)
SUM_W, 16, checksum width; sum wraps modulo 2^SUM_W
IDLE_CMD, 4'hF, cmd value driven whenever cmd_valid=0 (must never be 4'h0)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
in_cmd  input  4  upstream command code
in_valid  input  1  upstream command valid
in_ready  output  1  FIFO can accept (=!full)
cmd  output  4  command to controller
cmd_valid  output  1  command strobe, one cycle per command
busy  input  1  controller busy
done  input  1  controller write-back complete
IRAM_valid  input  1  controller IRAM write strobe
IRAM_A  input  6  IRAM write address
IRAM_D  input  8  IRAM write data
frame_done  output  1  one-cycle pulse, frame results updated
frame_sum  output  SUM_W  sum of IRAM_D over the last frame
frame_writes  output  7  IRAM writes in the last frame (64 expected)
drop_cnt  output  8  saturating count of rejected codes
seq_idle  output  1  FSM in IDLE and FIFO empty

Behaviour:
- Reset (reset=0, async) values: cmd=IDLE_CMD, cmd_valid=0, in_ready=1, frame_done=0, frame_sum=0, frame_writes=0, drop_cnt=0, seq_idle=1.
- Reset also clears the FIFO pointers, the accumulators, and sets state=IDLE. Reset mid-frame discards everything.
- Command codes 0..11 are legal; 0 = Write.
- Push rules:
  - Push occurs on in_valid & in_ready & in_cmd<=11.
  - in_valid & in_cmd>=12 is dropped regardless of full; drop_cnt increments and saturates at 255.
  - Push while full is impossible because in_ready=0.
- FIFO: registered read and write pointers, wrap at DEPTH; extra-bit full/empty detection. Simultaneous push and pop when full is allowed; count is unchanged.
- cmd and cmd_valid are registered. Whenever cmd_valid=0, cmd=IDLE_CMD. The controller changes state on cmd=0 even without cmd_valid, so 4'h0 appears on cmd only during a Write issue cycle.
- FSM states:
  - IDLE:
    - If busy=0 and FIFO non-empty: pop the head; next cycle drive cmd=head, cmd_valid=1.
    - Back-to-back issue is allowed, one command per cycle, while busy stays 0.
    - If the popped head is 0 (Write), go to WAIT_DONE.
    - busy=1 blocks issue (image load phase, and during write-back).
  - WAIT_DONE:
    - No pops; cmd=IDLE_CMD, cmd_valid=0; upstream pushes still accepted.
    - On done=1: pulse frame_done the next cycle; go to IDLE.
- Capture:
  - Every cycle with IRAM_valid=1: acc_sum += IRAM_D (zero-extended, wraps); acc_cnt += 1 (saturates at 127).
  - On done=1: frame_sum <= acc_sum plus the same-cycle write if any; frame_writes likewise; acc_sum and acc_cnt clear.
  - done=1 while in IDLE (spurious): results are latched and frame_done pulses, with no state change.
- IRAM_A is used only for checking: a write whose address is not the previous address+1 (first write expected at 0) sets a sticky internal order_err, cleared by reset. order_err is visible to the bench via a hierarchical reference only.
- Latency: push to cmd_valid is 2 cycles minimum (FIFO write, then registered issue).

Decomposition:
- Shared package lcd_pkg holds:
  - command code constants CMD_WRITE..CMD_MIRROR_Y (0..11)
  - CMD_LAST=11
  - the host FSM state enum (IDLE, WAIT_DONE)
  - image constants IMG_PIXELS=64 and ADDR_W=6
- One sub-module, lcd_cmd_fifo: parameterised synchronous FIFO with push, pop, full, empty and head data.
- The FSM and capture logic stay in lcd_host_seq.

Test Plan:
- Hold busy=1, push 1,4,7 -> no cmd_valid. Drop busy to 0 at cycle T -> cmd_valid high at T+1..T+3 with cmd=1,4,7; cmd=IDLE_CMD otherwise.
- Push 9 legal codes with busy=1 and DEPTH=8 -> in_ready=0 after the 8th push; 9th not accepted. Release busy -> exactly 8 issues, in order.
- Push 4'hC and 4'hF -> neither issued; drop_cnt=2. Push 300 illegal codes -> drop_cnt=255.
- Push 0 then 2, busy=0 -> cmd=0 issued and FSM enters WAIT_DONE. Code 2 is not issued until done pulses, then issues one cycle later.
- Drive 64 IRAM writes with A=D=0..63, then done -> frame_done pulse; frame_sum=2016; frame_writes=64; order_err=0.
- Assert reset low during WAIT_DONE with 3 FIFO entries -> all outputs return to reset values immediately; no further cmd_valid without new pushes.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host sequencer: command codes, image geometry
// and the host FSM state type.
package lcd_pkg;

    localparam int ADDR_W     = 6;
    localparam int IMG_PIXELS = 64;

    localparam logic [3:0] CMD_WRITE             = 4'd0;
    localparam logic [3:0] CMD_SHIFT_UP          = 4'd1;
    localparam logic [3:0] CMD_SHIFT_DOWN        = 4'd2;
    localparam logic [3:0] CMD_SHIFT_LEFT        = 4'd3;
    localparam logic [3:0] CMD_SHIFT_RIGHT       = 4'd4;
    localparam logic [3:0] CMD_MAX               = 4'd5;
    localparam logic [3:0] CMD_MIN               = 4'd6;
    localparam logic [3:0] CMD_AVERAGE           = 4'd7;
    localparam logic [3:0] CMD_COUNTER_CLOCKWISE = 4'd8;
    localparam logic [3:0] CMD_CLOCKWISE         = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X          = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y          = 4'd11;
    localparam logic [3:0] CMD_LAST              = CMD_MIRROR_Y;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } host_state_e;

    function automatic logic cmd_is_legal(input logic [3:0] code);
        return (code <= CMD_LAST);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with extra-bit pointers for full/empty detection.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [W-1:0] mem_r [DEPTH];
    logic         push_ok_s;
    logic         pop_ok_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    // A pop frees the slot in the same cycle, so a full FIFO may push and pop together.
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && !empty;

    // Pointer and storage update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wdata;
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/lcd_host_seq.sv
// Host-side sequencer for the LCD image controller: buffers commands, issues
// them when the controller is free, and checksums each IRAM write-back frame.
module lcd_host_seq
    import lcd_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter int         SUM_W    = 16,
    parameter logic [3:0] IDLE_CMD = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        in_cmd,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              done,
    input  logic              IRAM_valid,
    input  logic [ADDR_W-1:0] IRAM_A,
    input  logic [7:0]        IRAM_D,
    output logic              frame_done,
    output logic [SUM_W-1:0]  frame_sum,
    output logic [6:0]        frame_writes,
    output logic [7:0]        drop_cnt,
    output logic              seq_idle
);

    host_state_e       state_r;
    host_state_e       state_nxt_s;
    logic              full_s;
    logic              empty_s;
    logic [3:0]        head_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    logic [3:0]        cmd_nxt_s;
    logic              cmd_valid_nxt_s;
    logic [3:0]        cmd_r;
    logic              cmd_valid_r;
    logic              frame_done_r;
    logic [SUM_W-1:0]  frame_sum_r;
    logic [6:0]        frame_writes_r;
    logic [7:0]        drop_cnt_r;
    logic [SUM_W-1:0]  acc_sum_r;
    logic [6:0]        acc_cnt_r;
    logic [SUM_W-1:0]  sum_with_s;
    logic [6:0]        cnt_with_s;
    logic [ADDR_W-1:0] exp_addr_r;
    logic              order_err_r;

    assign push_s = in_valid && !full_s && cmd_is_legal(in_cmd);
    assign drop_s = in_valid && !cmd_is_legal(in_cmd);

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (4)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (in_cmd),
        .pop   (pop_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a Write issue parks the FSM until write-back completes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s && (head_s == CMD_WRITE)) begin
                    state_nxt_s = WAIT_DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: pop decision and the command presented on the next cycle.
    always_comb begin
        pop_s           = 1'b0;
        cmd_nxt_s       = IDLE_CMD;
        cmd_valid_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!busy && !empty_s) begin
                    pop_s           = 1'b1;
                    cmd_nxt_s       = head_s;
                    cmd_valid_nxt_s = 1'b1;
                end else begin
                    pop_s           = 1'b0;
                end
            end
            WAIT_DONE: begin
                pop_s = 1'b0;
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Registered command interface; cmd falls back to IDLE_CMD so 4'h0 never lingers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_r       <= IDLE_CMD;
            cmd_valid_r <= 1'b0;
        end else begin
            cmd_r       <= cmd_nxt_s;
            cmd_valid_r <= cmd_valid_nxt_s;
        end
    end

    // Saturating count of illegal upstream codes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    // Accumulator values including this cycle's write, used both to run and to close a frame.
    always_comb begin
        sum_with_s = acc_sum_r;
        cnt_with_s = acc_cnt_r;
        if (IRAM_valid) begin
            sum_with_s = acc_sum_r + SUM_W'(IRAM_D);
            cnt_with_s = (acc_cnt_r == 7'd127) ? acc_cnt_r : (acc_cnt_r + 7'd1);
        end else begin
            sum_with_s = acc_sum_r;
            cnt_with_s = acc_cnt_r;
        end
    end

    // Frame capture: done closes the frame whether or not a Write was outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_sum_r      <= '0;
            acc_cnt_r      <= 7'd0;
            frame_sum_r    <= '0;
            frame_writes_r <= 7'd0;
            frame_done_r   <= 1'b0;
        end else begin
            frame_done_r <= done;
            if (done) begin
                frame_sum_r    <= sum_with_s;
                frame_writes_r <= cnt_with_s;
                acc_sum_r      <= '0;
                acc_cnt_r      <= 7'd0;
            end else begin
                acc_sum_r      <= sum_with_s;
                acc_cnt_r      <= cnt_with_s;
            end
        end
    end

    // Address-order monitor; each frame is expected to start at address 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_addr_r  <= '0;
            order_err_r <= 1'b0;
        end else begin
            if (IRAM_valid && (IRAM_A != exp_addr_r)) begin
                order_err_r <= 1'b1;
            end else begin
                order_err_r <= order_err_r;
            end
            if (done) begin
                exp_addr_r <= '0;
            end else if (IRAM_valid) begin
                exp_addr_r <= IRAM_A + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                exp_addr_r <= exp_addr_r;
            end
        end
    end

    assign in_ready     = !full_s;
    assign seq_idle     = (state_r == IDLE) && empty_s;
    assign cmd          = cmd_r;
    assign cmd_valid    = cmd_valid_r;
    assign frame_done   = frame_done_r;
    assign frame_sum    = frame_sum_r;
    assign frame_writes = frame_writes_r;
    assign drop_cnt     = drop_cnt_r;

endmodule

// File: tb/tb_lcd_host_seq.sv
// Self-checking bench for lcd_host_seq: directed steps plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_lcd_host_seq;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_cmd;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        done;
    logic        iram_valid;
    logic [5:0]  iram_a;
    logic [7:0]  iram_d;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic [6:0]  frame_writes;
    logic [7:0]  drop_cnt;
    logic        seq_idle;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int          m_q[$];
    bit          m_wait;
    logic [3:0]  e_cmd;
    bit          e_cv;
    bit          e_fd;
    logic [15:0] e_sum;
    int          e_wr;
    logic [15:0] m_acc;
    int          m_cnt;
    int          e_drop;
    bit          m_oerr;
    int          m_exp;

    lcd_host_seq dut (
        .clk          (clk),
        .reset        (reset),
        .in_cmd       (in_cmd),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .busy         (busy),
        .done         (done),
        .IRAM_valid   (iram_valid),
        .IRAM_A       (iram_a),
        .IRAM_D       (iram_d),
        .frame_done   (frame_done),
        .frame_sum    (frame_sum),
        .frame_writes (frame_writes),
        .drop_cnt     (drop_cnt),
        .seq_idle     (seq_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wait = 1'b0;
        e_cmd  = 4'hF;
        e_cv   = 1'b0;
        e_fd   = 1'b0;
        e_sum  = 16'd0;
        e_wr   = 0;
        m_acc  = 16'd0;
        m_cnt  = 0;
        e_drop = 0;
        m_oerr = 1'b0;
        m_exp  = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held during the cycle.
    task automatic model_update();
        int  sz;
        int  c;
        bit  w_old;
        bit  do_pop;
        sz     = m_q.size();
        w_old  = m_wait;
        do_pop = !w_old && !busy && (sz > 0);
        e_cv   = 1'b0;
        e_cmd  = 4'hF;
        if (w_old) m_wait = !done;
        if (do_pop) begin
            c     = m_q.pop_front();
            e_cv  = 1'b1;
            e_cmd = 4'(c);
            if (c == 0) m_wait = 1'b1;
        end
        if (in_valid && in_cmd <= 4'd11 && sz < DEPTH) m_q.push_back(int'(in_cmd));
        if (in_valid && in_cmd >= 4'd12 && e_drop < 255) e_drop++;
        if (iram_valid) begin
            if (int'(iram_a) != m_exp) m_oerr = 1'b1;
            m_exp = (int'(iram_a) + 1) % 64;
        end
        if (done) m_exp = 0;
        e_fd = done;
        if (done) begin
            e_sum = m_acc + (iram_valid ? 16'(iram_d) : 16'd0);
            e_wr  = (iram_valid && m_cnt < 127) ? m_cnt + 1 : m_cnt;
            m_acc = 16'd0;
            m_cnt = 0;
        end else if (iram_valid) begin
            m_acc = m_acc + 16'(iram_d);
            if (m_cnt < 127) m_cnt++;
        end
    endtask

    task automatic check_all();
        chk("cmd",          32'(cmd),          32'(e_cmd));
        chk("cmd_valid",    32'(cmd_valid),    32'(e_cv));
        chk("in_ready",     32'(in_ready),     32'(m_q.size() < DEPTH));
        chk("frame_done",   32'(frame_done),   32'(e_fd));
        chk("frame_sum",    32'(frame_sum),    32'(e_sum));
        chk("frame_writes", 32'(frame_writes), 32'(e_wr));
        chk("drop_cnt",     32'(drop_cnt),     32'(e_drop));
        chk("seq_idle",     32'(seq_idle),     32'(!m_wait && m_q.size() == 0));
        chk("order_err",    32'(dut.order_err_r), 32'(m_oerr));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        in_valid   = 1'b0;
        in_cmd     = 4'd0;
        busy       = 1'b0;
        done       = 1'b0;
        iram_valid = 1'b0;
        iram_a     = 6'd0;
        iram_d     = 8'd0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd"},       32'(cmd),          32'hF);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid),    32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),     32'd1);
        chk({tag, "_frame_done"},32'(frame_done),   32'd0);
        chk({tag, "_frame_sum"}, 32'(frame_sum),    32'd0);
        chk({tag, "_writes"},    32'(frame_writes), 32'd0);
        chk({tag, "_drop_cnt"},  32'(drop_cnt),     32'd0);
        chk({tag, "_seq_idle"},  32'(seq_idle),     32'd1);
    endtask

    initial begin
        int issued;
        int seen[$];
        clear_inputs();
        model_reset();
        reset = 1'b0;
        #12;
        chk_reset_values("rst");
        @(posedge clk); #1;
        reset = 1'b1;

        // Held commands release one per cycle when busy drops
        busy = 1'b1;
        in_valid = 1'b1;
        in_cmd = 4'd1; step();
        in_cmd = 4'd4; step();
        in_cmd = 4'd7; step();
        in_valid = 1'b0;
        step(); step();
        chk("held_no_issue", 32'(cmd_valid), 32'd0);
        busy = 1'b0;
        step(); chk("b2b_0", {27'd0, cmd_valid, cmd}, {27'd0, 1'b1, 4'd1});
        step(); chk("b2b_1", {27'd0, cmd_valid, cmd}, {27'd0, 1'b1, 4'd4});
        step(); chk("b2b_2", {27'd0, cmd_valid, cmd}, {27'd0, 1'b1, 4'd7});
        step(); chk("b2b_end", {27'd0, cmd_valid, cmd}, {27'd0, 1'b0, 4'hF});

        // Fill to full, ninth push refused, then drain in order
        busy = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_cmd = 4'(i + 1);
            step();
            if (i == 7) chk("full_after_8", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        busy = 1'b0;
        issued = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cmd_valid) seen.push_back(int'(cmd));
        end
        chk("drain_count", 32'(seen.size()), 32'd8);
        for (int i = 0; i < seen.size(); i++) chk("drain_order", 32'(seen[i]), 32'(i + 1));

        // Illegal codes are dropped and the counter saturates
        in_valid = 1'b1;
        in_cmd = 4'hC; step();
        in_cmd = 4'hF; step();
        in_valid = 1'b0; step();
        chk("drop_two", 32'(drop_cnt), 32'd2);
        chk("drop_no_issue", 32'(cmd_valid), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_cmd = 4'($urandom_range(12, 15));
            step();
        end
        in_valid = 1'b0; step();
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Write holds off the next command until done
        busy = 1'b1;
        in_valid = 1'b1;
        in_cmd = 4'd0; step();
        in_cmd = 4'd2; step();
        in_valid = 1'b0;
        busy = 1'b0;
        step(); chk("write_issue", {27'd0, cmd_valid, cmd}, {27'd0, 1'b1, 4'd0});
        for (int i = 0; i < 4; i++) step();
        chk("wait_hold", 32'(cmd_valid), 32'd0);
        done = 1'b1; step();
        chk("wait_fd", 32'(frame_done), 32'd1);
        done = 1'b0; step();
        chk("after_done", {27'd0, cmd_valid, cmd}, {27'd0, 1'b1, 4'd2});
        step();

        // A full ordered frame of 64 writes
        for (int i = 0; i < 64; i++) begin
            iram_valid = 1'b1;
            iram_a = 6'(i);
            iram_d = 8'(i);
            step();
        end
        iram_valid = 1'b0;
        done = 1'b1; step();
        done = 1'b0;
        chk("frame_pulse", 32'(frame_done), 32'd1);
        chk("frame_sum_2016", 32'(frame_sum), 32'd2016);
        chk("frame_writes_64", 32'(frame_writes), 32'd64);
        chk("order_ok", 32'(dut.order_err_r), 32'd0);
        step();
        chk("frame_pulse_end", 32'(frame_done), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_cmd     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            busy       = ($urandom_range(0, 3) == 0);
            done       = ($urandom_range(0, 15) == 0);
            iram_valid = 1'($urandom_range(0, 1));
            iram_a     = 6'($urandom_range(0, 63));
            iram_d     = 8'($urandom_range(0, 255));
            step();
        end
        clear_inputs();
        for (int i = 0; i < 24; i++) begin
            done = (i % 6 == 0);
            step();
        end
        done = 1'b0;
        step();

        // Reset during WAIT_DONE with entries still queued
        busy = 1'b1;
        in_valid = 1'b1;
        in_cmd = 4'd0; step();
        in_cmd = 4'd5; step();
        in_cmd = 4'd6; step();
        in_cmd = 4'd7; step();
        in_valid = 1'b0;
        busy = 1'b0;
        step();
        step();
        chk("pre_rst_busy", 32'(seq_idle), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_reset_values("midrst");
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("post_rst_quiet", 32'(cmd_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
